// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_pkg
// Brief    : Shared states, protocol constants and helpers for the UART
//            command controller.
// Revision : 1.0
// ============================================================================
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] CMD_WR        = 8'h57;
  localparam logic [7:0] CMD_RD        = 8'h52;
  localparam logic [7:0] ACK           = 8'h06;
  localparam logic [7:0] NAK           = 8'h15;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    GET_CMD  = 4'd1,
    GET_ADDR = 4'd2,
    GET_DATA = 4'd3,
    GET_CHK  = 4'd4,
    EXEC     = 4'd5,
    RD_CAP   = 4'd6,
    SEND     = 4'd7,
    WAIT_TX  = 4'd8
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_timeout.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_timeout
// Brief    : Inter-byte silence counter; o_Expired marks the TIMEOUT_CLKS-th
//            consecutive enabled clock without a clear.
// Revision : 1.0
// ============================================================================
module uart_cmd_timeout #(
  parameter int TIMEOUT_CLKS = 25000
) (
  input  logic i_Clock,
  input  logic i_Rst_L,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Expired
);

  localparam int            CW     = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] r_Count;

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      r_Count <= '0;
    end else if (i_Clear || !i_Enable || o_Expired) begin
      r_Count <= '0;
    end else begin
      r_Count <= r_Count + 1'b1;
    end
  end

  assign o_Expired = i_Enable && (r_Count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_ctrl
// Brief    : UART framed register-access controller (SYNC CMD ADDR DATA CHK)
//            with ACK/NAK responses and inter-byte timeout.
// Revision : 1.0
// ============================================================================
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int         TIMEOUT_CLKS = 25000,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_Byte,
  input  logic       i_TX_Active,
  input  logic       i_TX_Done,
  output logic       o_Reg_Wr,
  output logic       o_Reg_Rd,
  output logic [7:0] o_Reg_Addr,
  output logic [7:0] o_Reg_Wr_Data,
  input  logic [7:0] i_Reg_Rd_Data,
  output logic       o_Busy,
  output logic [7:0] o_Err_Count
);

  state_t     r_State;
  logic [7:0] r_Cmd;
  logic [7:0] r_Reg_Addr;
  logic [7:0] r_Reg_Wr_Data;
  logic [7:0] r_Q0;
  logic [7:0] r_Q1;
  logic [1:0] r_Q_Cnt;
  logic       r_Rd_Phase;
  logic       r_TX_DV;
  logic [7:0] r_TX_Byte;
  logic       r_Reg_Wr;
  logic       r_Reg_Rd;
  logic [7:0] r_Err_Count;

  logic       w_In_Get;
  logic       w_Expired;
  logic       w_Cmd_Ok;
  logic [7:0] w_Chk_Exp;

  assign w_In_Get  = (r_State == GET_CMD) || (r_State == GET_ADDR) ||
                     (r_State == GET_DATA) || (r_State == GET_CHK);
  assign w_Cmd_Ok  = (r_Cmd == CMD_WR) || (r_Cmd == CMD_RD);
  assign w_Chk_Exp = r_Cmd ^ r_Reg_Addr ^ r_Reg_Wr_Data;

  uart_cmd_timeout #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_timeout (
    .i_Clock   (i_Clock),
    .i_Rst_L   (i_Rst_L),
    .i_Clear   (i_RX_DV),
    .i_Enable  (w_In_Get),
    .o_Expired (w_Expired)
  );

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      r_State       <= IDLE;
      r_Cmd         <= 8'h00;
      r_Reg_Addr    <= 8'h00;
      r_Reg_Wr_Data <= 8'h00;
      r_Q0          <= 8'h00;
      r_Q1          <= 8'h00;
      r_Q_Cnt       <= 2'd0;
      r_Rd_Phase    <= 1'b0;
      r_TX_DV       <= 1'b0;
      r_TX_Byte     <= 8'h00;
      r_Reg_Wr      <= 1'b0;
      r_Reg_Rd      <= 1'b0;
      r_Err_Count   <= 8'h00;
    end else begin
      r_TX_DV  <= 1'b0;
      r_Reg_Wr <= 1'b0;
      r_Reg_Rd <= 1'b0;

      case (r_State)
        IDLE: begin
          if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) r_State <= GET_CMD;
        end
        GET_CMD: begin
          if (i_RX_DV) begin
            r_Cmd   <= i_RX_Byte;
            r_State <= GET_ADDR;
          end
        end
        GET_ADDR: begin
          if (i_RX_DV) begin
            r_Reg_Addr <= i_RX_Byte;
            r_State    <= GET_DATA;
          end
        end
        GET_DATA: begin
          if (i_RX_DV) begin
            r_Reg_Wr_Data <= i_RX_Byte;
            r_State       <= GET_CHK;
          end
        end
        GET_CHK: begin
          if (i_RX_DV) begin
            if ((i_RX_Byte != w_Chk_Exp) || !w_Cmd_Ok) begin
              r_Q0        <= NAK;
              r_Q_Cnt     <= 2'd1;
              r_Err_Count <= sat_inc8(r_Err_Count);
              r_State     <= SEND;
            end else begin
              r_State <= EXEC;
            end
          end
        end
        EXEC: begin
          if (r_Cmd == CMD_WR) begin
            r_Reg_Wr <= 1'b1;
            r_Q0     <= ACK;
            r_Q_Cnt  <= 2'd1;
            r_State  <= SEND;
          end else begin
            r_Reg_Rd   <= 1'b1;
            r_Rd_Phase <= 1'b0;
            r_State    <= RD_CAP;
          end
        end
        RD_CAP: begin
          // Read data arrives in the cycle after the strobe cycle.
          if (!r_Rd_Phase) begin
            r_Rd_Phase <= 1'b1;
          end else begin
            r_Q0    <= ACK;
            r_Q1    <= i_Reg_Rd_Data;
            r_Q_Cnt <= 2'd2;
            r_State <= SEND;
          end
        end
        SEND: begin
          if (!i_TX_Active) begin
            r_TX_DV   <= 1'b1;
            r_TX_Byte <= r_Q0;
            r_Q0      <= r_Q1;
            r_Q_Cnt   <= r_Q_Cnt - 2'd1;
            r_State   <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          if (i_TX_Done) r_State <= (r_Q_Cnt != 2'd0) ? SEND : IDLE;
        end
        default: r_State <= IDLE;
      endcase

      // A byte arriving on the expiry cycle takes precedence over the timeout.
      if (w_Expired && !i_RX_DV) begin
        r_State     <= IDLE;
        r_Err_Count <= sat_inc8(r_Err_Count);
      end
    end
  end

  assign o_TX_DV       = r_TX_DV;
  assign o_TX_Byte     = r_TX_Byte;
  assign o_Reg_Wr      = r_Reg_Wr;
  assign o_Reg_Rd      = r_Reg_Rd;
  assign o_Reg_Addr    = r_Reg_Addr;
  assign o_Reg_Wr_Data = r_Reg_Wr_Data;
  assign o_Busy        = (r_State != IDLE);
  assign o_Err_Count   = r_Err_Count;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_ctrl
// Brief    : Scoreboard bench for uart_cmd_ctrl with TX and register models.
// Revision : 1.0
// ============================================================================
module tb_uart_cmd_ctrl;

  localparam int T = 40;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active = 1'b0;
  logic       tx_done = 1'b0;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_addr;
  logic [7:0] reg_wr_data;
  logic [7:0] rd_data = 8'hEE;
  logic [7:0] rd_value = 8'h00;
  logic       busy;
  logic [7:0] err_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_tx = 0, n_wr = 0, n_rd = 0;
  int tx_cyc = 0, wr_cyc = 0;
  int exp_err = 0;

  logic [7:0]  exp_tx[$];
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];

  uart_cmd_ctrl #(.TIMEOUT_CLKS(T)) dut (
    .i_Clock       (clk),
    .i_Rst_L       (rst_l),
    .i_RX_DV       (rx_dv),
    .i_RX_Byte     (rx_byte),
    .o_TX_DV       (tx_dv),
    .o_TX_Byte     (tx_byte),
    .i_TX_Active   (tx_active),
    .i_TX_Done     (tx_done),
    .o_Reg_Wr      (reg_wr),
    .o_Reg_Rd      (reg_rd),
    .o_Reg_Addr    (reg_addr),
    .o_Reg_Wr_Data (reg_wr_data),
    .i_Reg_Rd_Data (rd_data),
    .o_Busy        (busy),
    .o_Err_Count   (err_count)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: every strobe is matched against the scoreboard queues.
  initial forever begin
    @(negedge clk);
    if (rst_l) begin
      if (tx_dv) begin
        logic [7:0] e;
        checks++;
        n_tx++;
        tx_cyc = cyc;
        if (exp_tx.size() == 0) begin
          failures++;
          $display("FAIL tx_unexpected got=%h expected=none", tx_byte);
        end else begin
          e = exp_tx.pop_front();
          if (tx_byte !== e) begin
            failures++;
            $display("FAIL tx_byte got=%h expected=%h", tx_byte, e);
          end
        end
      end
      if (reg_wr) begin
        logic [15:0] e;
        checks++;
        n_wr++;
        wr_cyc = cyc;
        if (exp_wr.size() == 0) begin
          failures++;
          $display("FAIL wr_unexpected got=%h/%h expected=none", reg_addr, reg_wr_data);
        end else begin
          e = exp_wr.pop_front();
          if ({reg_addr, reg_wr_data} !== e) begin
            failures++;
            $display("FAIL wr_addr_data got=%h/%h expected=%h/%h", reg_addr, reg_wr_data, e[15:8], e[7:0]);
          end
        end
      end
      if (reg_rd) begin
        logic [7:0] e;
        checks++;
        n_rd++;
        if (exp_rd.size() == 0) begin
          failures++;
          $display("FAIL rd_unexpected got=%h expected=none", reg_addr);
        end else begin
          e = exp_rd.pop_front();
          if (reg_addr !== e) begin
            failures++;
            $display("FAIL rd_addr got=%h expected=%h", reg_addr, e);
          end
        end
      end
    end
  end

  // Transmitter model: busy for a few cycles after each request, then done.
  initial forever begin
    @(negedge clk);
    if (tx_dv) begin
      @(posedge clk); #1 tx_active = 1'b1;
      repeat (3) @(posedge clk);
      #1 tx_active = 1'b0; tx_done = 1'b1;
      @(posedge clk); #1 tx_done = 1'b0;
    end
  end

  // Register file model: data valid only in the cycle after the read strobe.
  initial forever begin
    @(negedge clk);
    if (reg_rd) begin
      @(posedge clk); #1 rd_data = rd_value;
      @(posedge clk); #1 rd_data = 8'hEE;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv = 1'b1;
    rx_byte = b;
    tick();
    rx_dv = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || exp_tx.size() != 0 || exp_wr.size() != 0 || exp_rd.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    repeat (3) tick();
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL idle_wait got=busy/pending expected=idle");
      exp_tx.delete(); exp_wr.delete(); exp_rd.delete();
    end
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    tick(); tick();
    checks++;
    if ({tx_dv, reg_wr, reg_rd, busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_strobes got=%b expected=0000", {tx_dv, reg_wr, reg_rd, busy});
    end
    checks++;
    if ({tx_byte, reg_addr, reg_wr_data, err_count} !== 32'h0) begin
      failures++;
      $display("FAIL reset_bytes got=%h expected=00000000", {tx_byte, reg_addr, reg_wr_data, err_count});
    end
    rst_l = 1'b1;
    tick();
  endtask

  task automatic test_write();
    int w0 = n_wr;
    int chk_cyc;
    exp_wr.push_back({8'h10, 8'h3C});
    exp_tx.push_back(8'h06);
    send_byte(8'hA5); send_byte(8'h57); send_byte(8'h10); send_byte(8'h3C);
    chk_cyc = cyc;
    send_byte(8'h7B);
    wait_idle(200);
    checks++;
    if (n_wr - w0 != 1) begin
      failures++;
      $display("FAIL write_count got=%0d expected=1", n_wr - w0);
    end
    checks++;
    if (wr_cyc - chk_cyc != 2) begin
      failures++;
      $display("FAIL write_latency got=%0d expected=2", wr_cyc - chk_cyc);
    end
    checks++;
    if (tx_cyc - wr_cyc != 1) begin
      failures++;
      $display("FAIL ack_latency got=%0d expected=1", tx_cyc - wr_cyc);
    end
    checks++;
    if ({reg_addr, reg_wr_data} !== 16'h103C) begin
      failures++;
      $display("FAIL write_hold got=%h expected=103c", {reg_addr, reg_wr_data});
    end
    checks++;
    if (err_count !== 8'(exp_err)) begin
      failures++;
      $display("FAIL write_err got=%0d expected=%0d", err_count, exp_err);
    end
  endtask

  task automatic test_read();
    int w0 = n_wr;
    int t0 = n_tx;
    rd_value = 8'h5A;
    exp_rd.push_back(8'h22);
    exp_tx.push_back(8'h06);
    exp_tx.push_back(8'h5A);
    send_byte(8'hA5); send_byte(8'h52); send_byte(8'h22); send_byte(8'h00); send_byte(8'h70);
    repeat (4) tick();
    send_byte(8'hA5);
    wait_idle(200);
    repeat (T + 5) tick();
    checks++;
    if (n_wr != w0 || n_tx - t0 != 2) begin
      failures++;
      $display("FAIL read_counts got=wr%0d/tx%0d expected=wr0/tx2", n_wr - w0, n_tx - t0);
    end
    checks++;
    if (busy !== 1'b0 || err_count !== 8'(exp_err)) begin
      failures++;
      $display("FAIL read_ignore_busy got=%b/%0d expected=0/%0d", busy, err_count, exp_err);
    end
  endtask

  task automatic test_bad_chk();
    int w0 = n_wr;
    int r0 = n_rd;
    exp_tx.push_back(8'h15);
    exp_err++;
    send_byte(8'hA5); send_byte(8'h57); send_byte(8'h10); send_byte(8'h3C); send_byte(8'h00);
    wait_idle(200);
    checks++;
    if (n_wr != w0 || n_rd != r0) begin
      failures++;
      $display("FAIL badchk_strobes got=wr%0d/rd%0d expected=0/0", n_wr - w0, n_rd - r0);
    end
    checks++;
    if (err_count !== 8'(exp_err)) begin
      failures++;
      $display("FAIL badchk_err got=%0d expected=%0d", err_count, exp_err);
    end
  endtask

  task automatic test_timeout();
    int t0 = n_tx;
    int w0 = n_wr;
    send_byte(8'hA5); send_byte(8'h57);
    exp_err++;
    repeat (T + 5) tick();
    checks++;
    if (busy !== 1'b0 || n_tx != t0 || err_count !== 8'(exp_err)) begin
      failures++;
      $display("FAIL timeout got=busy%b/tx%0d/err%0d expected=0/0/%0d", busy, n_tx - t0, err_count, exp_err);
    end
    exp_wr.push_back({8'h44, 8'h99});
    exp_tx.push_back(8'h06);
    send_byte(8'hA5); send_byte(8'h57); send_byte(8'h44); send_byte(8'h99); send_byte(8'h8A);
    wait_idle(200);
    checks++;
    if (n_wr - w0 != 1 || err_count !== 8'(exp_err)) begin
      failures++;
      $display("FAIL timeout_recover got=wr%0d/err%0d expected=1/%0d", n_wr - w0, err_count, exp_err);
    end
  endtask

  task automatic test_garbage();
    int w0 = n_wr;
    int t0 = n_tx;
    exp_wr.push_back({8'h10, 8'h3C});
    exp_tx.push_back(8'h06);
    send_byte(8'h00); send_byte(8'hFF);
    send_byte(8'hA5); send_byte(8'h57); send_byte(8'h10); send_byte(8'h3C); send_byte(8'h7B);
    wait_idle(200);
    checks++;
    if (n_wr - w0 != 1 || n_tx - t0 != 1 || err_count !== 8'(exp_err)) begin
      failures++;
      $display("FAIL garbage got=wr%0d/tx%0d/err%0d expected=1/1/%0d", n_wr - w0, n_tx - t0, err_count, exp_err);
    end
  endtask

  task automatic test_coincide();
    int w0 = n_wr;
    exp_wr.push_back({8'h01, 8'h02});
    exp_tx.push_back(8'h06);
    send_byte(8'hA5);
    repeat (T - 1) tick();
    send_byte(8'h57); send_byte(8'h01); send_byte(8'h02); send_byte(8'h54);
    wait_idle(200);
    checks++;
    if (n_wr - w0 != 1 || err_count !== 8'(exp_err)) begin
      failures++;
      $display("FAIL coincide got=wr%0d/err%0d expected=1/%0d", n_wr - w0, err_count, exp_err);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 260; i++) begin
      exp_tx.push_back(8'h15);
      send_byte(8'hA5); send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'hFF);
      wait_idle(200);
    end
    exp_err = 255;
    checks++;
    if (err_count !== 8'hFF) begin
      failures++;
      $display("FAIL saturate got=%0d expected=255", err_count);
    end
  endtask

  task automatic test_reset_mid();
    int t0 = n_tx;
    int n = 0;
    rd_value = 8'hA7;
    exp_rd.push_back(8'h30);
    exp_tx.push_back(8'h06);
    send_byte(8'hA5); send_byte(8'h52); send_byte(8'h30); send_byte(8'h00); send_byte(8'h62);
    while (n_tx == t0 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL resetmid_ack got=none expected=06");
    end
    tick();
    rst_l = 1'b0;
    tick();
    exp_err = 0;
    checks++;
    if ({tx_dv, reg_wr, reg_rd, busy} !== 4'b0000 || {tx_byte, reg_addr, reg_wr_data, err_count} !== 32'h0) begin
      failures++;
      $display("FAIL resetmid_outputs got=%b/%h expected=0000/00000000",
               {tx_dv, reg_wr, reg_rd, busy}, {tx_byte, reg_addr, reg_wr_data, err_count});
    end
    tick();
    rst_l = 1'b1;
    repeat (20) tick();
    checks++;
    if (n_tx - t0 != 1 || busy !== 1'b0 || err_count !== 8'h00 || exp_tx.size() != 0) begin
      failures++;
      $display("FAIL resetmid_after got=tx%0d/busy%b/err%0d expected=1/0/0", n_tx - t0, busy, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_chk();
    test_timeout();
    test_garbage();
    test_coincide();
    test_saturate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CLKS, default 25000, meaning the inter-byte timeout in clocks (1 ms at 25 MHz).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the frame start marker.
REQ-003 SHALL have port i_Clock  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_Rst_L  in  1  synchronous, active-low reset.
REQ-005 SHALL have port i_RX_DV  in  1  one-cycle strobe for a received UART byte.
REQ-006 SHALL have port i_RX_Byte  in  8  received byte, valid with i_RX_DV.
REQ-007 SHALL have port o_TX_DV  out  1  one-cycle request to the UART transmitter.
REQ-008 SHALL have port o_TX_Byte  out  8  byte to transmit, valid with o_TX_DV.
REQ-009 SHALL have port i_TX_Active  in  1  transmitter is busy.
REQ-010 SHALL have port i_TX_Done  in  1  one-cycle strobe when the transmitter finishes a byte.
REQ-011 SHALL have port o_Reg_Wr  out  1  one-cycle register write strobe.
REQ-012 SHALL have port o_Reg_Rd  out  1  one-cycle register read strobe.
REQ-013 SHALL have port o_Reg_Addr  out  8  register address.
REQ-014 SHALL have port o_Reg_Wr_Data  out  8  write data.
REQ-015 SHALL have port i_Reg_Rd_Data  in  8  read data, valid exactly 1 cycle after o_Reg_Rd.
REQ-016 SHALL have port o_Busy  out  1  high in every state except IDLE.
REQ-017 SHALL have port o_Err_Count  out  8  number of frame errors, saturating at 255.

Function
REQ-018 SHALL accept 5-byte frames: SYNC, CMD, ADDR, DATA, CHK, with CHK = CMD^ADDR^DATA; CMD 8'h57 = write, 8'h52 = read (DATA is ignored for reads but is still included in CHK).
REQ-019 SHALL use states IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, EXEC, RD_CAP, SEND, WAIT_TX.
REQ-020 SHALL, in IDLE, discard every byte other than SYNC_BYTE; SYNC moves the FSM to GET_CMD.
REQ-021 SHALL, in the GET_* states, latch the byte on i_RX_DV and advance; a SYNC-valued byte mid-frame is treated as data.
REQ-022 SHALL, on a checksum mismatch or unknown CMD at GET_CHK, queue NAK 8'h15, increment o_Err_Count, and go to SEND.
REQ-023 SHALL, in EXEC for a write, pulse o_Reg_Wr for 1 cycle with Addr/Wr_Data, then queue ACK 8'h06.
REQ-024 SHALL, in EXEC for a read, pulse o_Reg_Rd, capture i_Reg_Rd_Data in RD_CAP on the next cycle, then queue ACK followed by the data byte.
REQ-025 SHALL, in SEND, wait until i_TX_Active=0, then pulse o_TX_DV with o_TX_Byte for 1 cycle and go to WAIT_TX.
REQ-026 SHALL, in WAIT_TX on i_TX_Done, return to SEND if a byte remains queued, else to IDLE.
REQ-027 SHALL give a latency of 2 cycles from the i_RX_DV of CHK to o_Reg_Wr, and 1 cycle from o_Reg_Wr to the first ACK o_TX_DV when TX is idle.
REQ-028 SHALL count clocks without i_RX_DV in GET_CMD..GET_CHK; on reaching TIMEOUT_CLKS it returns to IDLE silently and increments o_Err_Count.
REQ-029 SHALL, when i_RX_DV and timeout expiry occur in the same cycle, let the byte win: the counter clears and no error is counted.
REQ-030 SHALL ignore and not count bytes received in EXEC, RD_CAP, SEND and WAIT_TX.
REQ-031 SHALL keep o_Err_Count at 255 on further errors (saturating, no wrap).
REQ-032 SHALL hold o_Reg_Addr and o_Reg_Wr_Data stable from EXEC until the next frame's ADDR/DATA latch.

Reset
REQ-033 SHALL, while i_Rst_L=0 at a clock edge, set the FSM to IDLE and clear the queue, the timeout counter and o_Err_Count.
REQ-034 SHALL drive o_TX_DV, o_Reg_Wr, o_Reg_Rd and o_Busy to 0, and o_TX_Byte, o_Reg_Addr and o_Reg_Wr_Data to 8'h00, during reset.
REQ-035 SHALL abandon any partial frame or pending response on reset mid-operation, with no strobe issued afterwards.

Structure
REQ-036 SHALL place the state encoding and the constants SYNC_BYTE default, CMD_WR, CMD_RD, ACK and NAK in shared package uart_cmd_pkg.
REQ-037 SHALL implement the inter-byte timeout counter as sub-module uart_cmd_timeout (inputs: clear, enable; output: expired).

Verification
REQ-038 SHALL cover: write frame A5 57 10 3C 7B -> one o_Reg_Wr, Addr=10, Data=3C; then TX 06; o_Err_Count=0.
REQ-039 SHALL cover: read frame A5 52 22 00 70 with Rd_Data=5A -> o_Reg_Rd, then TX 06 then 5A; no o_Reg_Wr.
REQ-040 SHALL cover: bad checksum A5 57 10 3C 00 -> no register strobe, TX 15, o_Err_Count=1.
REQ-041 SHALL cover: A5 57 then silence for TIMEOUT_CLKS -> IDLE, no TX, o_Err_Count=1; a following valid frame completes normally.
REQ-042 SHALL cover: garbage 00 FF then a valid write frame -> leading bytes ignored, a single write and ACK.
REQ-043 SHALL cover: i_Rst_L low during WAIT_TX of a read response -> no second TX byte, all outputs at reset values, o_Err_Count=0.
